// File: rtl/crc_frame_ctrl_pkg.sv
// Shared definitions for the CRC frame controller slice.
//   - CRC-32 constants (reflected polynomial, good-frame residue)
//   - controller state encoding
//   - single-bit LSB-first CRC step
package crc_frame_ctrl_pkg;

  localparam int unsigned CRC_W = 32;
  typedef logic [CRC_W-1:0] crc_t;

  localparam crc_t P_CRC32       = 32'hEDB88320;
  localparam crc_t RESIDUE_CRC32 = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_END,
    ST_FCS
  } state_e;

  // One reflected CRC step: shift right, fold in the polynomial when the
  // outgoing LSB differs from the incoming data bit.
  function automatic crc_t crc_step_bit(input crc_t crc, input logic d, input crc_t poly);
    crc_step_bit = (crc >> 1) ^ ((crc[0] ^ d) ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_frame_ctrl_step.sv
// crc_step_par: purely combinational parallel CRC update.
//   crc_in  : current accumulator
//   data    : H-bit beat, bit 0 applied first
//   crc_out : accumulator after H single-bit steps
module crc_step_par
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned H = 8,
  parameter crc_t        P = P_CRC32
) (
  input  crc_t         crc_in,
  input  logic [H-1:0] data,
  output crc_t         crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < H; i++) begin
      crc_out = crc_step_bit(crc_out, data[i], P);
    end
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: streaming frame controller around a parallel LSB-first CRC.
// Append mode forwards the payload and then emits ~crc (W/H beats, LSB first).
// Check mode forwards the whole frame and pulses crc_ok/crc_err on the residue.
//   clk, reset_n              : clock, asynchronous active-low reset
//   s_data/s_valid/s_last     : input beat stream; s_mode sampled on first beat
//   s_ready                   : controller accepts an input beat
//   m_data/m_valid/m_last     : registered output beat stream
//   m_ready                   : sink accepts an output beat
//   crc_ok/crc_err            : one-cycle check-mode verdict
//   busy                      : frame in progress or output still pending
// The CRC register width is fixed by crc_t; W must equal CRC_W.
module crc_frame_ctrl
  import crc_frame_ctrl_pkg::*;
#(
  parameter int unsigned H       = 8,
  parameter int unsigned W       = 32,
  parameter crc_t        P       = P_CRC32,
  parameter crc_t        RESIDUE = RESIDUE_CRC32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [H-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic         s_mode,
  output logic         s_ready,
  output logic [H-1:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         crc_ok,
  output logic         crc_err,
  output logic         busy
);

  localparam int unsigned FCS_BEATS = W / H;
  localparam int unsigned CNT_W     = $clog2(FCS_BEATS + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam logic SINGLE_FCS = (FCS_BEATS == 1);

  state_e       state_q, state_d;
  logic         mode_q, mode_d;
  crc_t         crc_q, crc_d;
  crc_t         fcs_q, fcs_d;
  cnt_t         fcs_cnt_q, fcs_cnt_d;
  logic         m_valid_q, m_valid_d;
  logic [H-1:0] m_data_q, m_data_d;
  logic         m_last_q, m_last_d;

  crc_t         crc_next;
  crc_t         fcs_init;
  logic         out_free;
  logic         out_xfer;
  logic         accept;

  crc_step_par #(
    .H (H),
    .P (P)
  ) u_step (
    .crc_in  (crc_q),
    .data    (s_data),
    .crc_out (crc_next)
  );

  assign out_free = !m_valid_q || m_ready;
  assign out_xfer = m_valid_q && m_ready;
  assign s_ready  = reset_n && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_free;
  assign accept   = s_valid && s_ready;
  assign fcs_init = ~crc_q;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE) || m_valid_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    crc_d     = crc_q;
    fcs_d     = fcs_q;
    fcs_cnt_d = fcs_cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    crc_ok    = 1'b0;
    crc_err   = 1'b0;

    if (out_xfer) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d    = s_mode;
          crc_d     = crc_next;
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          // In check mode the final data beat is the frame's last output beat.
          m_last_d  = s_last && s_mode;
          state_d   = s_last ? ST_END : ST_DATA;
        end
      end

      ST_DATA: begin
        if (accept) begin
          crc_d     = crc_next;
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = s_last && mode_q;
          if (s_last) begin
            state_d = ST_END;
          end
        end
      end

      ST_END: begin
        if (mode_q) begin
          crc_ok  = (crc_q == RESIDUE);
          crc_err = (crc_q != RESIDUE);
          crc_d   = '1;
          state_d = ST_IDLE;
        end else if (out_free) begin
          // First FCS beat goes straight into the output register so the
          // FCS follows the last payload beat without a gap on m_*.
          m_valid_d = 1'b1;
          m_data_d  = fcs_init[H-1:0];
          m_last_d  = SINGLE_FCS;
          fcs_d     = fcs_init >> H;
          fcs_cnt_d = cnt_t'(FCS_BEATS - 1);
          state_d   = ST_FCS;
        end
      end

      ST_FCS: begin
        if (fcs_cnt_q != '0) begin
          if (out_free) begin
            m_valid_d = 1'b1;
            m_data_d  = fcs_q[H-1:0];
            m_last_d  = (fcs_cnt_q == cnt_t'(1));
            fcs_d     = fcs_q >> H;
            fcs_cnt_d = fcs_cnt_q - cnt_t'(1);
          end
        end else if (out_xfer) begin
          crc_d   = '1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      crc_q     <= '1;
      fcs_q     <= '0;
      fcs_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      crc_q     <= crc_d;
      fcs_q     <= fcs_d;
      fcs_cnt_q <= fcs_cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed self-checking bench for crc_frame_ctrl using the "123456789"
// CRC-32 check vector (CRC = 0xCBF43926, FCS bytes 26 39 F4 CB).
module tb_crc_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_mode = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       crc_ok;
  logic       crc_err;
  logic       busy;

  crc_frame_ctrl #(
    .H (8),
    .W (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_mode  (s_mode),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .crc_ok  (crc_ok),
    .crc_err (crc_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [3:0] rdy_pat = 4'b1111;
  int         rdy_idx = 0;

  logic [7:0] msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0] fcs [0:3] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

  logic [7:0] tx_data[$];
  logic       tx_last[$];
  logic       tx_mode[$];
  int         acc_cyc[$];

  logic [7:0] out_data[$];
  logic       out_last[$];
  int         out_cyc[$];
  int         ok_cnt, err_cnt, both_cnt, ok_cyc, err_cyc, stall_viol;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  logic [7:0] exp_data[$];
  logic       exp_last[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_pat[rdy_idx];
    rdy_idx = (rdy_idx + 1) % 4;
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stall_viol++;
      if (m_valid && m_ready) begin
        out_data.push_back(m_data);
        out_last.push_back(m_last);
        out_cyc.push_back(cyc);
      end
      if (crc_ok) begin ok_cnt++; ok_cyc = cyc; end
      if (crc_err) begin err_cnt++; err_cyc = cyc; end
      if (crc_ok && crc_err) both_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic clear_mon();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    ok_cnt = 0; err_cnt = 0; both_cnt = 0;
    ok_cyc = -1; err_cyc = -1; stall_viol = 0;
  endtask

  // 9 message beats (optionally one with bit 0 flipped), optional FCS beats.
  // Beats after the first carry the opposite s_mode, which must be ignored.
  task automatic queue_frame(input logic mode, input logic with_fcs, input int flip_idx);
    int n;
    n = with_fcs ? 13 : 9;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = (i < 9) ? msg[i] : fcs[i-9];
      if (i == flip_idx) b[0] = ~b[0];
      tx_data.push_back(b);
      tx_last.push_back(i == n - 1);
      tx_mode.push_back((i == 0) ? mode : ~mode);
    end
  endtask

  function automatic void build_expected(input int flip_idx);
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < 13; i++) begin
      logic [7:0] b;
      b = (i < 9) ? msg[i] : fcs[i-9];
      if (i == flip_idx) b[0] = ~b[0];
      exp_data.push_back(b);
      exp_last.push_back(i == 12);
    end
  endfunction

  task automatic drive_all();
    int   n;
    logic done;
    int   waited;
    n = tx_data.size();
    acc_cyc.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = tx_data[i];
      s_last  = tx_last[i];
      s_mode  = tx_mode[i];
      done    = 1'b0;
      waited  = 0;
      while (!done && waited < 200) begin
        @(negedge clk);
        done = (s_ready === 1'b1);
        @(posedge clk);
        #1;
        waited++;
      end
      if (!done) begin
        checks++;
        $display("FAIL drive_timeout beat=%0d got=stalled exp=accepted", i);
        break;
      end
      acc_cyc.push_back(cyc);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tx_data.delete();
    tx_last.delete();
    tx_mode.delete();
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = (busy === 1'b0);
    end
    if (!idle) begin
      checks++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got=%b exp=0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL rst_m_data got=%h exp=00", m_data); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL rst_m_last got=%b exp=0", m_last); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b exp=0", s_ready); else passed++;
    checks++; if (crc_ok !== 1'b0) $display("FAIL rst_crc_ok got=%b exp=0", crc_ok); else passed++;
    checks++; if (crc_err !== 1'b0) $display("FAIL rst_crc_err got=%b exp=0", crc_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) $display("FAIL idle_s_ready got=%b exp=1", s_ready); else passed++;
  endtask

  task automatic test_append();
    clear_mon();
    queue_frame(1'b0, 1'b0, -1);
    drive_all();
    wait_idle();
    build_expected(-1);
    checks++;
    if (out_data.size() !== 13) $display("FAIL app_count got=%0d exp=13", out_data.size());
    else passed++;
    for (int i = 0; i < 13 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL app_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    checks++;
    if (ok_cnt + err_cnt !== 0) $display("FAIL app_no_pulse got=%0d exp=0", ok_cnt + err_cnt);
    else passed++;
    if (out_cyc.size() >= 13) begin
      checks++;
      if (out_cyc[0] !== acc_cyc[0]) $display("FAIL app_latency got=%0d exp=%0d", out_cyc[0], acc_cyc[0]);
      else passed++;
      checks++;
      if (out_cyc[9] !== out_cyc[8] + 1) $display("FAIL app_fcs_start got=%0d exp=%0d", out_cyc[9], out_cyc[8] + 1);
      else passed++;
      checks++;
      if (out_cyc[12] - out_cyc[0] !== 12) $display("FAIL app_span got=%0d exp=12", out_cyc[12] - out_cyc[0]);
      else passed++;
    end
  endtask

  task automatic test_check_good();
    clear_mon();
    queue_frame(1'b1, 1'b1, -1);
    drive_all();
    wait_idle();
    build_expected(-1);
    checks++;
    if (out_data.size() !== 13) $display("FAIL chk_count got=%0d exp=13", out_data.size());
    else passed++;
    for (int i = 0; i < 13 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL chk_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    checks++; if (ok_cnt !== 1) $display("FAIL chk_ok_cnt got=%0d exp=1", ok_cnt); else passed++;
    checks++; if (err_cnt !== 0) $display("FAIL chk_err_cnt got=%0d exp=0", err_cnt); else passed++;
    checks++; if (both_cnt !== 0) $display("FAIL chk_both got=%0d exp=0", both_cnt); else passed++;
    checks++;
    if (ok_cyc !== acc_cyc[acc_cyc.size()-1])
      $display("FAIL chk_ok_time got=%0d exp=%0d", ok_cyc, acc_cyc[acc_cyc.size()-1]);
    else passed++;
  endtask

  task automatic test_check_bad();
    clear_mon();
    queue_frame(1'b1, 1'b1, 4);
    drive_all();
    wait_idle();
    build_expected(4);
    checks++;
    if (out_data.size() !== 13) $display("FAIL bad_count got=%0d exp=13", out_data.size());
    else passed++;
    for (int i = 0; i < 13 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL bad_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    checks++; if (err_cnt !== 1) $display("FAIL bad_err_cnt got=%0d exp=1", err_cnt); else passed++;
    checks++; if (ok_cnt !== 0) $display("FAIL bad_ok_cnt got=%0d exp=0", ok_cnt); else passed++;
    checks++;
    if (err_cyc !== acc_cyc[acc_cyc.size()-1])
      $display("FAIL bad_err_time got=%0d exp=%0d", err_cyc, acc_cyc[acc_cyc.size()-1]);
    else passed++;
  endtask

  task automatic test_backpressure();
    clear_mon();
    @(posedge clk);
    rdy_pat = 4'b1001;
    rdy_idx = 0;
    queue_frame(1'b0, 1'b0, -1);
    drive_all();
    wait_idle();
    rdy_pat = 4'b1111;
    build_expected(-1);
    checks++;
    if (out_data.size() !== 13) $display("FAIL bp_count got=%0d exp=13", out_data.size());
    else passed++;
    for (int i = 0; i < 13 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    checks++;
    if (stall_viol !== 0) $display("FAIL bp_stable got=%0d exp=0", stall_viol);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int lasts;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      tx_data.push_back(msg[i]);
      tx_last.push_back(1'b0);
      tx_mode.push_back(1'b0);
    end
    drive_all();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) $display("FAIL abort_m_valid got=%b exp=0", m_valid); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL abort_s_ready got=%b exp=0", s_ready); else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    lasts = 0;
    foreach (out_last[i]) if (out_last[i]) lasts++;
    checks++; if (lasts !== 0) $display("FAIL abort_m_last got=%0d exp=0", lasts); else passed++;
    checks++;
    if (ok_cnt + err_cnt !== 0) $display("FAIL abort_pulse got=%0d exp=0", ok_cnt + err_cnt);
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    clear_mon();
    queue_frame(1'b0, 1'b0, -1);
    drive_all();
    wait_idle();
    build_expected(-1);
    checks++;
    if (out_data.size() !== 13) $display("FAIL abort_count got=%0d exp=13", out_data.size());
    else passed++;
    for (int i = 9; i < 13 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL abort_fcs%0d got=%h/%b exp=%h/%b", i - 9, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    tx_data.push_back(8'hA5);
    tx_last.push_back(1'b1);
    tx_mode.push_back(1'b1);
    queue_frame(1'b0, 1'b0, -1);
    drive_all();
    wait_idle();
    build_expected(-1);
    exp_data.push_front(8'hA5);
    exp_last.push_front(1'b1);
    checks++;
    if (out_data.size() !== 14) $display("FAIL b2b_count got=%0d exp=14", out_data.size());
    else passed++;
    for (int i = 0; i < 14 && i < out_data.size(); i++) begin
      checks++;
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i])
        $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
      else passed++;
    end
    checks++; if (err_cnt !== 1) $display("FAIL b2b_err_cnt got=%0d exp=1", err_cnt); else passed++;
    checks++; if (ok_cnt !== 0) $display("FAIL b2b_ok_cnt got=%0d exp=0", ok_cnt); else passed++;
    if (acc_cyc.size() >= 2) begin
      checks++;
      if (err_cyc !== acc_cyc[0]) $display("FAIL b2b_err_time got=%0d exp=%0d", err_cyc, acc_cyc[0]);
      else passed++;
      checks++;
      if (acc_cyc[1] !== acc_cyc[0] + 2) $display("FAIL b2b_restart got=%0d exp=%0d", acc_cyc[1], acc_cyc[0] + 2);
      else passed++;
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_append();
    test_check_good();
    test_check_bad();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
